mac8_accum_pipe: RTL and testbench

- Pipelined multiply-accumulate stage that takes a stream of 8-bit operand pairs.
- Each pair is multiplied by one instance of the team's 8-bit combinational multiplier (multiplier_8bits_version12). The 16-bit products are summed over a frame delimited by in_last.
- Each completed frame emits one accumulated result on a valid/ready output.
- The block sits between the operand-delivery logic and the dot-product consumer. It turns the purely combinational multiplier into a registered, back-pressurable stage.

---
 rtl/mac8_accum_pipe_pkg.sv | 15 +
 rtl/mac8_accum_pipe_mult.sv | 24 ++
 rtl/mac8_accum_pipe.sv | 94 +++++++++
 tb/tb_mac8_accum_pipe.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac8_accum_pipe_pkg.sv
// Shared constants and stage types for the pipelined 8-bit multiply-accumulate block.
package mac8_accum_pipe_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;
    localparam int PROD_W    = 16;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       last;
        logic       valid;
    } s1_t;

endpackage

// File: rtl/mac8_accum_pipe_mult.sv
// Combinational 8x8 unsigned multiplier: sum of shifted partial products.
module multiplier_8bits_version12 (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p
);

    logic [15:0] pp [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = b[gi] ? (16'({8'd0, a}) << gi) : 16'd0;
        end
    endgenerate

    always_comb begin
        p = '0;
        for (int i = 0; i < 8; i++) begin
            p = p + pp[i];
        end
    end

endmodule

// File: rtl/mac8_accum_pipe.sv
// Three-stage MAC: operand register, product register, frame accumulator with
// a valid/ready result port. Every stage freezes while a result is back-pressured.
module mac8_accum_pipe
    import mac8_accum_pipe_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    s1_t               s1_reg;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] s2_prod_reg;
    logic              s2_last_reg;
    logic              s2_valid_reg;
    logic [ACC_W-1:0]  acc_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              ovf_reg;

    logic              stall;
    logic [ACC_W:0]    sum_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_next;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    multiplier_8bits_version12 u_mult (
        .a (s1_reg.a),
        .b (s1_reg.b),
        .p (prod)
    );

    // One extra bit on the sum captures the carry that feeds the sticky overflow.
    assign sum_next = {1'b0, acc_reg} + {{(ACC_W + 1 - PROD_W){1'b0}}, s2_prod_reg};
    assign cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_W'(1);
    assign ovf_next = ovf_reg | sum_next[ACC_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_reg       <= '0;
            s2_prod_reg  <= '0;
            s2_last_reg  <= 1'b0;
            s2_valid_reg <= 1'b0;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            out_valid    <= 1'b0;
            out_acc      <= '0;
            out_count    <= '0;
            out_ovf      <= 1'b0;
        end else if (!stall) begin
            s1_reg.a     <= in_a;
            s1_reg.b     <= in_b;
            s1_reg.last  <= in_last;
            s1_reg.valid <= in_valid & in_ready;

            s2_prod_reg  <= prod;
            s2_last_reg  <= s1_reg.last;
            s2_valid_reg <= s1_reg.valid;

            // Not stalled means any held result is being taken this cycle.
            out_valid <= 1'b0;
            if (s2_valid_reg) begin
                if (s2_last_reg) begin
                    out_acc   <= sum_next[ACC_W-1:0];
                    out_count <= cnt_next;
                    out_ovf   <= ovf_next;
                    out_valid <= 1'b1;
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    ovf_reg   <= 1'b0;
                end else begin
                    acc_reg   <= sum_next[ACC_W-1:0];
                    cnt_reg   <= cnt_next;
                    ovf_reg   <= ovf_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac8_accum_pipe.sv
// Self-checking bench: two instances (24- and 16-bit accumulators) in lockstep,
// directed frame table, hand-written stall/reset sequences, random traffic vs. a frame-sum model.
module tb_mac8_accum_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        in_last;
    logic        out_ready;
    logic        in_ready, in_ready16;
    logic        out_valid, out_valid16;
    logic [23:0] out_acc;
    logic [15:0] out_acc16;
    logic [7:0]  out_count, out_count16;
    logic        out_ovf, out_ovf16;

    always #5 clk = ~clk;

    mac8_accum_pipe #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_count(out_count), .out_ovf(out_ovf)
    );

    mac8_accum_pipe #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid16), .out_ready(out_ready),
        .out_acc(out_acc16), .out_count(out_count16), .out_ovf(out_ovf16)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference model: a frame is just its exact sum of products and its length.
    typedef struct {
        longint total;
        int     n;
    } frame_t;

    frame_t exp_q[$];
    longint cur_total = 0;
    int     cur_n     = 0;
    logic   prev_stall = 1'b0;
    logic [23:0] prev_acc;
    logic [7:0]  prev_cnt;
    logic        prev_ovf;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            cur_total  = 0;
            cur_n      = 0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", longint'(in_ready), longint'(!(out_valid && !out_ready)));
            chk("lockstep_valid", longint'(out_valid16), longint'(out_valid));
            if (prev_stall) begin
                chk("hold_acc", longint'(out_acc), longint'(prev_acc));
                chk("hold_cnt", longint'(out_count), longint'(prev_cnt));
                chk("hold_ovf", longint'(out_ovf), longint'(prev_ovf));
            end
            if (in_valid && in_ready) begin
                cur_total += longint'(in_a) * longint'(in_b);
                cur_n++;
                if (in_last) begin
                    exp_q.push_back('{cur_total, cur_n});
                    cur_total = 0;
                    cur_n     = 0;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    frame_t f;
                    f = exp_q.pop_front();
                    $display("result: acc=%0d cnt=%0d ovf=%0d acc16=%0d ovf16=%0d model_total=%0d n=%0d",
                             out_acc, out_count, out_ovf, out_acc16, out_ovf16, f.total, f.n);
                    chk("sb_acc24", longint'(out_acc), f.total % (64'd1 << 24));
                    chk("sb_ovf24", longint'(out_ovf), longint'(f.total >= (64'd1 << 24)));
                    chk("sb_cnt", longint'(out_count), longint'((f.n > 255) ? 255 : f.n));
                    chk("sb_acc16", longint'(out_acc16), f.total % (64'd1 << 16));
                    chk("sb_ovf16", longint'(out_ovf16), longint'(f.total >= (64'd1 << 16)));
                    chk("sb_cnt16", longint'(out_count16), longint'(out_count));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_acc   = out_acc;
            prev_cnt   = out_count;
            prev_ovf   = out_ovf;
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && cur_n == 0 && !out_valid) break;
            @(posedge clk);
        end
        #1;
        chk("drain_empty", longint'(exp_q.size()), 0);
    endtask

    typedef struct {
        int              n;
        logic [2:0][7:0] a;
        logic [2:0][7:0] b;
        int              acc24;
        int              cnt;
        int              ovf24;
        int              acc16;
        int              ovf16;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input int n,
                           input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2,
                           input int acc24, input int cnt, input int ovf24,
                           input int acc16, input int ovf16);
        vecs[i].n     = n;
        vecs[i].a[0]  = 8'(a0); vecs[i].b[0] = 8'(b0);
        vecs[i].a[1]  = 8'(a1); vecs[i].b[1] = 8'(b1);
        vecs[i].a[2]  = 8'(a2); vecs[i].b[2] = 8'(b2);
        vecs[i].acc24 = acc24;
        vecs[i].cnt   = cnt;
        vecs[i].ovf24 = ovf24;
        vecs[i].acc16 = acc16;
        vecs[i].ovf16 = ovf16;
    endtask

    bit rand_done;

    initial begin
        set_vec(0, 3,   3,   4,   5,   6,   7,   8,     98, 3, 0,    98, 0);
        set_vec(1, 1, 255, 255,   0,   0,   0,   0,  65025, 1, 0, 65025, 0);
        set_vec(2, 2, 255, 255, 255, 255,   0,   0, 130050, 2, 0, 64514, 1);
        set_vec(3, 1,   1,   1,   0,   0,   0,   0,      1, 1, 0,     1, 0);
        set_vec(4, 2,   0, 200,  10,   0,   0,   0,      0, 2, 0,     0, 0);
        set_vec(5, 3, 200, 100,  50,  50, 128,   2,  22756, 3, 0, 22756, 0);
        set_vec(6, 3, 255, 255, 255, 255, 255, 255, 195075, 3, 0, 64003, 1);

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_acc", longint'(out_acc), 0);
        chk("rst_out_count", longint'(out_count), 0);
        chk("rst_out_ovf", longint'(out_ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        align();

        // Latency: out_valid must appear exactly three cycles after the last pair is taken.
        send(3, 4, 0);
        send(5, 6, 0);
        send(7, 8, 1);
        @(negedge clk); chk("lat_t1", longint'(out_valid), 0);
        @(negedge clk); chk("lat_t2", longint'(out_valid), 0);
        @(negedge clk); chk("lat_t3", longint'(out_valid), 1);
        chk("lat_acc", longint'(out_acc), 98);
        align();
        drain();
        align();

        // Directed frame table.
        for (int v = 0; v < 7; v++) begin
            for (int p = 0; p < vecs[v].n; p++) begin
                send(vecs[v].a[p], vecs[v].b[p], p == vecs[v].n - 1);
            end
            wait_valid(10);
            $display("vec %0d: acc=%0d cnt=%0d ovf=%0d acc16=%0d ovf16=%0d",
                     v, out_acc, out_count, out_ovf, out_acc16, out_ovf16);
            chk("tbl_acc24", longint'(out_acc), longint'(vecs[v].acc24));
            chk("tbl_cnt", longint'(out_count), longint'(vecs[v].cnt));
            chk("tbl_ovf24", longint'(out_ovf), longint'(vecs[v].ovf24));
            chk("tbl_acc16", longint'(out_acc16), longint'(vecs[v].acc16));
            chk("tbl_ovf16", longint'(out_ovf16), longint'(vecs[v].ovf16));
            align();
        end
        drain();
        align();

        // Back-pressure with pairs of later frames still inside S1/S2.
        out_ready = 1'b0;
        fork
            begin
                send(3, 4, 0);
                send(5, 6, 0);
                send(7, 8, 1);
                send(255, 255, 1);
                send(1, 2, 0);
                send(3, 4, 1);
            end
            begin
                wait_valid(30);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready", longint'(in_ready), 0);
                    chk("stall_acc", longint'(out_acc), 98);
                    chk("stall_cnt", longint'(out_count), 3);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        align();

        // Single-pair frames back to back: one result per cycle.
        fork
            begin
                send(1, 1, 1);
                send(2, 2, 1);
                send(3, 3, 1);
            end
            begin
                wait_valid(20);
                chk("stream_v0", longint'(out_valid), 1);
                chk("stream_acc0", longint'(out_acc), 1);
                @(negedge clk);
                chk("stream_v1", longint'(out_valid), 1);
                chk("stream_acc1", longint'(out_acc), 4);
                @(negedge clk);
                chk("stream_v2", longint'(out_valid), 1);
                chk("stream_acc2", longint'(out_acc), 9);
            end
        join
        align();
        drain();
        align();

        // Reset in the middle of a frame discards the partial sum.
        send(5, 5, 0);
        send(6, 6, 0);
        rst = 1'b1;
        align();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", longint'(out_valid), 0);
        align();
        send(2, 3, 1);
        wait_valid(10);
        chk("midrst_acc", longint'(out_acc), 6);
        chk("midrst_cnt", longint'(out_count), 1);
        align();
        drain();
        align();

        // Random frames, random bubbles, random back-pressure, then one saturating frame.
        rand_done = 0;
        fork
            begin
                for (int f = 0; f < 40; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int p = 0; p < len; p++) begin
                        if ($urandom_range(0, 3) == 0) align();
                        send(8'($urandom), 8'($urandom), p == len - 1);
                    end
                end
                for (int p = 0; p < 300; p++) begin
                    send(255, 255, p == 299);
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    align();
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
